// File: rtl/dmem_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_pkg                                                     |
// | Description : Shared types and helpers for the data-memory responder.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WEN_READ = 4'b0000;

    // Counter holds LATENCY-1, so clog2(LATENCY) bits suffice (min 1).
    function automatic int cnt_width(input int latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder_if                                            |
// | Description : Core data-port bundle between pipeline M-stage and memory.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dmem_responder_if;
    logic        req;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    modport master (
        output req, wen, addr, wdata,
        input  rdata, stall, err
    );

    modport slave (
        input  req, wen, addr, wdata,
        output rdata, stall, err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_ram.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_ram                                                     |
// | Description : Single-port 2**AW x 32 RAM, synchronous read, byte enables. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_ram
    import dmem_pkg::*;
#(
    parameter int AW = 10
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          en_i,
    input  wire logic [3:0]    we_i,
    input  wire logic [AW-1:0] addr_i,
    input  wire logic [31:0]   wdata_i,
    output      logic [31:0]   rdata_o
);

    // One byte-wide array per lane keeps the write enables independent.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem_q [2**AW];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_q <= '0;
            end else if (en_i) begin
                if (we_i[i]) begin
                    mem_q[addr_i] <= wdata_i[8*i +: 8];
                end else if (we_i == WEN_READ) begin
                    rd_q <= mem_q[addr_i];
                end
            end
        end

        assign rdata_o[8*i +: 8] = rd_q;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Fixed-latency data-memory responder with pipeline stall.    |
// |               Optional address fault check: DMEM_BOUNDS_CHECK_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input wire logic         clk,
    input wire logic         rst,
    dmem_responder_if.slave  bus
);

    localparam int CW = cnt_width(LATENCY);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      wen_q;
    logic [31:0]     wdata_q;
    logic            fault_q;
    logic            fault_d;
    logic            err_q;
    logic            ram_en;
    logic [31:0]     ram_rdata;
    logic            unused_addr_bits;

    always_comb begin
        fault_d = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        fault_d = (bus.addr[31:AW+2] != '0) ||
                  ((bus.wen != WEN_READ) && (bus.addr[1:0] != 2'b00));
`endif
    end

    assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (bus.req) begin
                        idx_q   <= bus.addr[AW+1:2];
                        wen_q   <= bus.wen;
                        wdata_q <= bus.wdata;
                        fault_q <= fault_d;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        err_q   <= fault_q;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // RAM op fires on the last BUSY cycle; a reset edge never commits it.
    assign ram_en = rst && (state_q == ST_BUSY) && (cnt_q == '0) && !fault_q;

    dmem_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ram_en),
        .we_i    (wen_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign bus.stall = rst && ((bus.req && (state_q == ST_IDLE)) || (state_q == ST_BUSY));
    assign bus.rdata = err_q ? 32'h0 : ram_rdata;
    assign bus.err   = err_q;

endmodule

`default_nettype wire
